// File: rtl/pe_pkg.sv
// rtl/pe_pkg.sv - shared widths and types for the systolic array PEs
package pe_pkg;

   localparam int DEFAULT_DATA_WIDTH = 32;

   function automatic int acc_width(input int data_width);
      return 2 * data_width;
   endfunction

   localparam int ACC_WIDTH = acc_width(DEFAULT_DATA_WIDTH);

   typedef logic [DEFAULT_DATA_WIDTH-1:0] operand_t;
   typedef logic [ACC_WIDTH-1:0]          acc_t;

endpackage

// File: rtl/pe_mac.sv
// rtl/pe_mac.sv - combinational multiply-accumulate with overflow detect
// SYSTOLIC_PE_SATURATE_EN clamps the result to all ones on overflow.
module pe_mac
   import pe_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   localparam int ACC_W = acc_width(DATA_WIDTH)
) (
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b,
   input  logic [ACC_W-1:0]      acc,
   output logic [ACC_W-1:0]      acc_next,
   output logic                  ovf
);

   logic [ACC_W-1:0] product;
   logic [ACC_W:0]   sum;

   // Operands are zero-extended so the full-width product is never truncated.
   assign product = ACC_W'(a) * ACC_W'(b);
   assign sum     = {1'b0, acc} + {1'b0, product};
   assign ovf     = sum[ACC_W];

`ifdef SYSTOLIC_PE_SATURATE_EN
   // Once at all ones, any nonzero product overflows again, so it stays pinned.
   assign acc_next = ovf ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
   assign acc_next = sum[ACC_W-1:0];
`endif

endmodule

// File: rtl/systolic_pe.sv
// rtl/systolic_pe.sv - output-stationary systolic PE: accumulate and forward
// Optional SYSTOLIC_PE_SATURATE_EN selects saturating accumulation in pe_mac.
module systolic_pe
   import pe_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   localparam int ACC_W = acc_width(DATA_WIDTH)
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [DATA_WIDTH-1:0] up_i,
   input  logic [DATA_WIDTH-1:0] left_i,
   output logic [DATA_WIDTH-1:0] down_o,
   output logic [DATA_WIDTH-1:0] right_o,
   output logic [ACC_W-1:0]      res_o,
   output logic                  carry_o
);

   logic [ACC_W-1:0] acc_next;
   logic             ovf;

   pe_mac #(.DATA_WIDTH(DATA_WIDTH)) u_mac (
      .a        (up_i),
      .b        (left_i),
      .acc      (res_o),
      .acc_next (acc_next),
      .ovf      (ovf)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         down_o  <= '0;
         right_o <= '0;
         res_o   <= '0;
         carry_o <= 1'b0;
      end else begin
         down_o  <= up_i;
         right_o <= left_i;
         res_o   <= acc_next;
         carry_o <= carry_o | ovf;
      end
   end

endmodule

// File: tb/tb_systolic_pe.sv
// tb/tb_systolic_pe.sv - self-checking bench for systolic_pe
// Honours SYSTOLIC_PE_SATURATE_EN in its reference model.
module tb_systolic_pe;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] up, left;
   logic [31:0] down_o, right_o;
   logic [63:0] res_o;
   logic        carry_o;

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   logic [31:0] m_down, m_right;
   logic [63:0] m_res;
   logic        m_carry;

   systolic_pe #(.DATA_WIDTH(32)) dut (
      .clk_i   (clk),
      .rst_i   (rst),
      .up_i    (up),
      .left_i  (left),
      .down_o  (down_o),
      .right_o (right_o),
      .res_o   (res_o),
      .carry_o (carry_o)
   );

   always #5 clk = ~clk;

   // Exact 65-bit sum of accumulator and full product.
   function automatic logic [64:0] exact_sum(input logic [63:0] acc, input logic [31:0] a, input logic [31:0] b);
      logic [64:0] wide;
      wide = 65'(acc) + 65'(a) * 65'(b);
      return wide;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_down  <= 32'd0;
         m_right <= 32'd0;
         m_res   <= 64'd0;
         m_carry <= 1'b0;
      end else begin
         m_down  <= up;
         m_right <= left;
         m_carry <= m_carry | exact_sum(m_res, up, left)[64];
`ifdef SYSTOLIC_PE_SATURATE_EN
         m_res   <= exact_sum(m_res, up, left)[64] ? 64'hFFFF_FFFF_FFFF_FFFF : exact_sum(m_res, up, left)[63:0];
`else
         m_res   <= exact_sum(m_res, up, left)[63:0];
`endif
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("down_o",  64'(down_o),  64'(m_down));
         chk("right_o", 64'(right_o), 64'(m_right));
         chk("res_o",   res_o,        m_res);
         chk("carry_o", 64'(carry_o), 64'(m_carry));
      end
   end

   task automatic drive(input logic r, input logic [31:0] u, input logic [31:0] l, input int n);
      rst  = r;
      up   = u;
      left = l;
      repeat (n) @(negedge clk);
   endtask

   initial begin
      chk_en = 1'b1;

      drive(1'b1, 32'd5, 32'd3, 4);
      chk("rst_res", res_o, 64'd0);
      chk("rst_carry", 64'(carry_o), 64'd0);
      chk("rst_down", 64'(down_o), 64'd0);
      chk("rst_right", 64'(right_o), 64'd0);

      drive(1'b0, 32'd5, 32'd3, 1);
      chk("acc1_down", 64'(down_o), 64'd5);
      chk("acc1_right", 64'(right_o), 64'd3);
      chk("acc1_res", res_o, 64'd15);
      drive(1'b0, 32'd5, 32'd3, 1);
      chk("acc2_res", res_o, 64'd30);
      drive(1'b0, 32'd5, 32'd3, 3);
      chk("acc5_res", res_o, 64'd75);
      chk("acc5_model", m_res, 64'd75);

      drive(1'b0, 32'd7, 32'd0, 3);
      chk("zero_down", 64'(down_o), 64'd7);
      chk("zero_right", 64'(right_o), 64'd0);
      chk("zero_res", res_o, 64'd75);

      drive(1'b1, 32'd0, 32'd0, 1);
      drive(1'b0, 32'd5, 32'd3, 3);
      chk("mid_pre", res_o, 64'd45);
      drive(1'b1, 32'd5, 32'd3, 1);
      chk("mid_rst_res", res_o, 64'd0);
      chk("mid_rst_carry", 64'(carry_o), 64'd0);
      drive(1'b0, 32'd5, 32'd3, 1);
      chk("mid_restart", res_o, 64'd15);

      drive(1'b1, 32'd0, 32'd0, 1);
      drive(1'b0, 32'h0001_0000, 32'h0001_0000, 1);
      chk("wide_prod", res_o, 64'h0000_0001_0000_0000);
      drive(1'b0, 32'h8000_0000, 32'd4, 1);
      chk("wide_prod2", res_o, 64'h0000_0003_0000_0000);

      drive(1'b1, 32'd0, 32'd0, 1);
      drive(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
      chk("ovf1_res", res_o, 64'hFFFF_FFFE_0000_0001);
      chk("ovf1_carry", 64'(carry_o), 64'd0);
      drive(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
`ifdef SYSTOLIC_PE_SATURATE_EN
      chk("ovf2_res", res_o, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("ovf2_model", m_res, 64'hFFFF_FFFF_FFFF_FFFF);
`else
      chk("ovf2_res", res_o, 64'hFFFF_FFFC_0000_0002);
      chk("ovf2_model", m_res, 64'hFFFF_FFFC_0000_0002);
`endif
      chk("ovf2_carry", 64'(carry_o), 64'd1);
      drive(1'b0, 32'd0, 32'd0, 2);
      chk("sticky_carry", 64'(carry_o), 64'd1);
      drive(1'b0, 32'd2, 32'd3, 2);
`ifdef SYSTOLIC_PE_SATURATE_EN
      chk("sat_hold", res_o, 64'hFFFF_FFFF_FFFF_FFFF);
`else
      chk("wrap_more", res_o, 64'hFFFF_FFFC_0000_000E);
`endif
      chk("sticky_carry2", 64'(carry_o), 64'd1);

      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
